// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and access sequencer for a single-port
// 1024 x 32 data memory with registered read. Port 0 is the CPU load/store
// unit and port 1 is the program/debug loader. Each access runs in three
// cycles: IDLE (grant) -> ISSUE (strobe) -> WAIT (capture). The ack pulse,
// read data and error flag are all registered.
module dmem_arbiter #(
  parameter logic [31:0] MEM_DEPTH = 32'd1024,
  parameter logic [31:0] PROT_ADDR = 32'd1022
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] dataW0,
  input  logic [31:0] dataW1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] memAddr,
  output logic [31:0] memDataW,
  output logic        memEnaR,
  output logic        memEnaW,
  input  logic [31:0] memDataOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // An access is legal when it hits real memory and is not a write to the
  // reserved input-port word (reads of that word are allowed).
  function automatic logic is_legal(input logic we, input logic [31:0] addr);
    logic in_range;
    logic prot_hit;
    in_range = (addr < MEM_DEPTH);
    prot_hit = we && (addr == PROT_ADDR);
    return in_range && !prot_hit;
  endfunction

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;          // 0 favours port 0 on contention
  logic        gnt_q, gnt_d;          // port currently being served
  logic        we_q, we_d;
  logic        legal_q, legal_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_dataw_q, mem_dataw_d;
  logic        mem_ena_r_q, mem_ena_r_d;
  logic        mem_ena_w_q, mem_ena_w_d;

  logic        elig0_s, elig1_s;
  logic        take_s, sel_s, contend_s;
  logic        sel_we_s, sel_legal_s;
  logic [31:0] sel_addr_s, sel_dataw_s;

  // Arbitration: a port in its ack cycle is skipped so a request that is
  // just being dropped is not served twice.
  always_comb begin
    elig0_s   = req0 & ~ack0_q;
    elig1_s   = req1 & ~ack1_q;
    take_s    = 1'b0;
    sel_s     = 1'b0;
    contend_s = 1'b0;
    if (elig0_s && elig1_s) begin
      take_s    = 1'b1;
      sel_s     = ptr_q;
      contend_s = 1'b1;
    end else if (elig0_s) begin
      take_s    = 1'b1;
      sel_s     = 1'b0;
    end else if (elig1_s) begin
      take_s    = 1'b1;
      sel_s     = 1'b1;
    end else begin
      take_s    = 1'b0;
      sel_s     = 1'b0;
    end
    sel_we_s    = sel_s ? we1    : we0;
    sel_addr_s  = sel_s ? addr1  : addr0;
    sel_dataw_s = sel_s ? dataW1 : dataW0;
    sel_legal_s = is_legal(sel_we_s, sel_addr_s);
  end

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    legal_d     = legal_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = err0_q;
    err1_d      = err1_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_addr_d  = mem_addr_q;
    mem_dataw_d = mem_dataw_q;
    mem_ena_r_d = 1'b0;
    mem_ena_w_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (take_s) begin
          if (contend_s) begin
            ptr_d = ~sel_s;
          end else begin
            ptr_d = ptr_q;
          end
          gnt_d       = sel_s;
          we_d        = sel_we_s;
          legal_d     = sel_legal_s;
          // Memory-facing registers load now so they are valid during ISSUE.
          mem_addr_d  = sel_addr_s;
          mem_dataw_d = sel_dataw_s;
          mem_ena_w_d = sel_we_s & sel_legal_s;
          mem_ena_r_d = ~sel_we_s & sel_legal_s;
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        state_d = IDLE;
        if (gnt_q == 1'b0) begin
          ack0_d   = 1'b1;
          err0_d   = ~legal_q;
          rdata0_d = (~we_q & legal_q) ? memDataOut : 32'd0;
        end else begin
          ack1_d   = 1'b1;
          err1_d   = ~legal_q;
          rdata1_d = (~we_q & legal_q) ? memDataOut : 32'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access and drops strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      legal_q     <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= 32'd0;
      rdata1_q    <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_dataw_q <= 32'd0;
      mem_ena_r_q <= 1'b0;
      mem_ena_w_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      legal_q     <= legal_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_addr_q  <= mem_addr_d;
      mem_dataw_q <= mem_dataw_d;
      mem_ena_r_q <= mem_ena_r_d;
      mem_ena_w_q <= mem_ena_w_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign memAddr  = mem_addr_q;
  assign memDataW = mem_dataw_q;
  assign memEnaR  = mem_ena_r_q;
  assign memEnaW  = mem_ena_w_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 1024 x 32
// registered-read memory attached to the memory port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = 32'd0, addr1 = 32'd0;
  logic [31:0] dataW0 = 32'd0, dataW1 = 32'd0;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] memAddr, memDataW;
  logic        memEnaR, memEnaW;
  logic [31:0] memDataOut;

  int checks = 0;
  int errors = 0;

  // Event counters, sampled mid-cycle on the falling edge.
  int enaw_cnt = 0;
  int enar_cnt = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  int clash_cnt = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] mem_dout = 32'd0;
  logic        mem_init = 1'b0;

  dmem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .dataW0     (dataW0),
    .dataW1     (dataW1),
    .ack0       (ack0),
    .ack1       (ack1),
    .rdata0     (rdata0),
    .rdata1     (rdata1),
    .err0       (err0),
    .err1       (err1),
    .memAddr    (memAddr),
    .memDataW   (memDataW),
    .memEnaR    (memEnaR),
    .memEnaW    (memEnaW),
    .memDataOut (memDataOut)
  );

  assign memDataOut = mem_dout;

  always #5 clk = ~clk;

  // Memory model: word i starts as 0x1000_0000 + i; registered read.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + i;
      mem_init <= 1'b1;
    end else if (memEnaW) begin
      mem[memAddr[9:0]] <= memDataW;
    end
    if (memEnaR) mem_dout <= mem[memAddr[9:0]];
  end

  // Strobe/ack event counters.
  always @(negedge clk) begin
    if (memEnaW) enaw_cnt <= enaw_cnt + 1;
    if (memEnaR) enar_cnt <= enar_cnt + 1;
    if (ack0) ack0_cnt <= ack0_cnt + 1;
    if (ack1) ack1_cnt <= ack1_cnt + 1;
    if (memEnaR && memEnaW) clash_cnt <= clash_cnt + 1;
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (port == 0) begin
      req0 = r; we0 = w; addr0 = a; dataW0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; dataW1 = d;
    end
  endtask

  // One uncontended access; request starts in cycle 0, ack expected in cycle 3.
  task automatic do_access(input string tag, input int port, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic exp_err, input logic [31:0] exp_rdata,
                           input int exp_w, input int exp_r);
    int bw, br;
    bw = enaw_cnt;
    br = enar_cnt;
    set_req(port, 1'b1, w, a, d);
    tick; // cycle 1: ISSUE
    check32({tag, "_c1_ack"}, 32'(port == 0 ? ack0 : ack1), 32'd0);
    check32({tag, "_c1_addr"}, memAddr, a);
    check32({tag, "_c1_enaw"}, 32'(memEnaW), 32'(exp_w));
    check32({tag, "_c1_enar"}, 32'(memEnaR), 32'(exp_r));
    tick; // cycle 2: WAIT
    check32({tag, "_c2_ack"}, 32'(port == 0 ? ack0 : ack1), 32'd0);
    check32({tag, "_c2_ena"}, 32'({memEnaR, memEnaW}), 32'd0);
    tick; // cycle 3: ack
    check32({tag, "_c3_ack"}, 32'(port == 0 ? ack0 : ack1), 32'd1);
    check32({tag, "_c3_err"}, 32'(port == 0 ? err0 : err1), 32'(exp_err));
    check32({tag, "_c3_rdata"}, port == 0 ? rdata0 : rdata1, exp_rdata);
    set_req(port, 1'b0, w, a, d);
    tick; // cycle 4
    check32({tag, "_c4_ack"}, 32'(port == 0 ? ack0 : ack1), 32'd0);
    check32({tag, "_nwr"}, 32'(enaw_cnt - bw), 32'(exp_w));
    check32({tag, "_nrd"}, 32'(enar_cnt - br), 32'(exp_r));
  endtask

  initial begin
    int nack, k0, k1, b0, bw;
    int order [0:15];
    logic [31:0] a0, a1;

    // Reset state
    tick; tick; tick;
    check32("rst_ack", 32'({ack0, ack1}), 32'd0);
    check32("rst_err", 32'({err0, err1}), 32'd0);
    check32("rst_rdata0", rdata0, 32'd0);
    check32("rst_rdata1", rdata1, 32'd0);
    check32("rst_maddr", memAddr, 32'd0);
    check32("rst_mdataw", memDataW, 32'd0);
    check32("rst_ena", 32'({memEnaR, memEnaW}), 32'd0);
    rst_n = 1'b1;
    tick;

    // 1: write then read back @5
    do_access("t1_wr", 0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 32'd0, 1, 0);
    check32("t1_mdataw", memDataW, 32'hDEAD_BEEF);
    do_access("t1_rd", 0, 1'b0, 32'd5, 32'd0, 1'b0, 32'hDEAD_BEEF, 0, 1);

    // 2: contention, both held continuously; grants must alternate 0,1,0,1...
    a0 = 32'd1; a1 = 32'd2; k0 = 0; k1 = 0; nack = 0;
    set_req(0, 1'b1, 1'b0, a0, 32'd0);
    set_req(1, 1'b1, 1'b0, a1, 32'd0);
    for (int c = 1; c <= 36; c++) begin
      tick;
      if (ack0 && ack1) check32("t2_dual_ack", 32'({ack0, ack1}), 32'd0);
      if (ack0) begin
        check32("t2_ack0_cycle", 32'(c), 32'(3 * (nack + 1)));
        check32("t2_rdata0", rdata0, 32'h1000_0000 + a0);
        if (nack < 16) order[nack] = 0;
        nack++; k0++;
        a0 = 32'(10 + k0);
        set_req(0, k0 < 5, 1'b0, a0, 32'd0);
      end
      if (ack1) begin
        check32("t2_ack1_cycle", 32'(c), 32'(3 * (nack + 1)));
        check32("t2_rdata1", rdata1, 32'h1000_0000 + a1);
        if (nack < 16) order[nack] = 1;
        nack++; k1++;
        a1 = 32'(20 + k1);
        set_req(1, k1 < 5, 1'b0, a1, 32'd0);
      end
    end
    check32("t2_nack", 32'(nack), 32'd10);
    for (int i = 0; i < 10; i++) check32($sformatf("t2_order%0d", i), 32'(order[i]), 32'(i % 2));

    // 3: protected word: write rejected, read allowed
    do_access("t3_wr", 1, 1'b1, 32'd1022, 32'hCAFE_F00D, 1'b1, 32'd0, 0, 0);
    do_access("t3_rd", 1, 1'b0, 32'd1022, 32'd0, 1'b0, 32'h1000_03FE, 0, 1);

    // 4: out-of-range reads
    do_access("t4_1024", 0, 1'b0, 32'd1024, 32'd0, 1'b1, 32'd0, 0, 0);
    do_access("t4_ffff", 0, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 0, 0);

    // 5: request held through its ack cycle -> one access only
    b0 = ack0_cnt; bw = enaw_cnt;
    set_req(0, 1'b1, 1'b1, 32'd7, 32'h1234_5678);
    tick; tick; tick;
    check32("t5_c3_ack", 32'(ack0), 32'd1);
    tick;
    set_req(0, 1'b0, 1'b1, 32'd7, 32'h1234_5678);
    for (int c = 0; c < 8; c++) tick;
    check32("t5_nack", 32'(ack0_cnt - b0), 32'd1);
    check32("t5_nwr", 32'(enaw_cnt - bw), 32'd1);
    do_access("t5_rd", 0, 1'b0, 32'd7, 32'd0, 1'b0, 32'h1234_5678, 0, 1);

    // 6: reset during WAIT of a port-1 read
    set_req(1, 1'b1, 1'b0, 32'd2, 32'd0);
    tick;
    check32("t6_c1_enar", 32'(memEnaR), 32'd1);
    tick;
    rst_n = 1'b0;
    #1;
    check32("t6_rst_enar", 32'(memEnaR), 32'd0);
    check32("t6_rst_ack1", 32'(ack1), 32'd0);
    check32("t6_rst_rdata1", rdata1, 32'd0);
    check32("t6_rst_maddr", memAddr, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd2, 32'd0);
    tick; tick;
    rst_n = 1'b1;
    b0 = ack1_cnt;
    for (int c = 0; c < 6; c++) tick;
    check32("t6_no_ack1", 32'(ack1_cnt - b0), 32'd0);
    do_access("t6_rd0", 0, 1'b0, 32'd5, 32'd0, 1'b0, 32'hDEAD_BEEF, 0, 1);

    check32("strobe_clash", 32'(clash_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
